// File: rtl/kf_priority_controller_n_if.sv
// Bus bundle between the N-channel priority controller and its CPU-interface /
// control logic. The master side drives requests, modes and strobes; the slave
// side is the controller itself.
interface kf_priority_controller_n_if #(
   parameter int unsigned CHANNELS = 8,
   parameter int unsigned ID_WIDTH = $clog2(CHANNELS)
);
   logic [CHANNELS-1:0] irq;
   logic                level_triggered;
   logic [CHANNELS-1:0] interrupt_mask;
   logic                special_mask_mode;
   logic                auto_rotate;
   logic                set_priority;
   logic [ID_WIDTH-1:0] set_priority_id;
   logic                ack;
   logic                eoi;
   logic                eoi_specific;
   logic [ID_WIDTH-1:0] eoi_id;
   logic                int_out;
   logic                ack_valid;
   logic [ID_WIDTH-1:0] ack_id;
   logic [CHANNELS-1:0] interrupt_request_register;
   logic [CHANNELS-1:0] in_service_register;
   logic [ID_WIDTH-1:0] priority_pointer;

   modport master (
      output irq, level_triggered, interrupt_mask, special_mask_mode, auto_rotate,
             set_priority, set_priority_id, ack, eoi, eoi_specific, eoi_id,
      input  int_out, ack_valid, ack_id, interrupt_request_register, in_service_register,
             priority_pointer
   );

   modport slave (
      input  irq, level_triggered, interrupt_mask, special_mask_mode, auto_rotate,
             set_priority, set_priority_id, ack, eoi, eoi_specific, eoi_id,
      output int_out, ack_valid, ack_id, interrupt_request_register, in_service_register,
             priority_pointer
   );
endinterface

// File: rtl/kf_priority_controller_n.sv
// N-channel priority controller: request latching (edge or level), in-service
// register, rotating priority pointer and an ack/EOI handshake FSM.
module kf_priority_controller_n #(
   parameter int unsigned CHANNELS = 8,
   parameter int unsigned ID_WIDTH = $clog2(CHANNELS)
) (
   input logic                       clock,
   input logic                       reset_n,
   kf_priority_controller_n_if.slave bus
);

   typedef enum logic {StIdle, StPending} state_t;

   localparam logic [ID_WIDTH-1:0] LastId    = ID_WIDTH'(CHANNELS - 1);
   localparam logic [ID_WIDTH:0]   ChanCount = (ID_WIDTH + 1)'(CHANNELS);

   state_t              state;
   logic [CHANNELS-1:0] irr;
   logic [CHANNELS-1:0] isr;
   logic [CHANNELS-1:0] irq_prev;
   logic [ID_WIDTH-1:0] pointer;
   logic [ID_WIDTH-1:0] grant_id;
   logic                int_req;
   logic                ack_pulse;

   logic [CHANNELS-1:0] eff_isr;
   logic [CHANNELS-1:0] cand;
   logic [CHANNELS-1:0] grant_vec;
   logic [CHANNELS-1:0] eoi_clear;
   logic                win_found;
   logic                isr_found;
   logic                grant;
   logic                eoi_hit;
   logic                set_ok;
   logic [ID_WIDTH-1:0] win_id;
   logic [ID_WIDTH-1:0] top_isr_id;
   logic [ID_WIDTH-1:0] eoi_k;

   // Successor index with wrap at CHANNELS-1, so the pointer never leaves 0..CHANNELS-1.
   function automatic logic [ID_WIDTH-1:0] next_id(logic [ID_WIDTH-1:0] id);
      return (id == LastId) ? '0 : id + ID_WIDTH'(1);
   endfunction

   // Walk channels from the pointer downwards; a candidate wins only if it is seen
   // before the first effective in-service bit (strictly higher priority).
   always_comb begin
      logic [ID_WIDTH:0]   sum;
      logic [ID_WIDTH-1:0] idx;
      sum        = '0;
      idx        = '0;
      eff_isr    = bus.special_mask_mode ? (isr & ~bus.interrupt_mask) : isr;
      cand       = irr & ~bus.interrupt_mask;
      win_found  = 1'b0;
      isr_found  = 1'b0;
      win_id     = '0;
      top_isr_id = '0;
      for (int unsigned i = 0; i < CHANNELS; i++) begin
         sum = {1'b0, pointer} + (ID_WIDTH + 1)'(i);
         if (sum >= ChanCount) sum = sum - ChanCount;
         idx = sum[ID_WIDTH-1:0];
         if (!isr_found && eff_isr[idx]) begin
            isr_found  = 1'b1;
            top_isr_id = idx;
         end
         if (!win_found && !isr_found && cand[idx]) begin
            win_found = 1'b1;
            win_id    = idx;
         end
      end
   end

   // Select the ISR bit an EOI would clear; specific EOIs on idle or
   // out-of-range channels do nothing.
   always_comb begin
      eoi_hit = 1'b0;
      eoi_k   = '0;
      if (bus.eoi) begin
         if (bus.eoi_specific) begin
            for (int unsigned i = 0; i < CHANNELS; i++) begin
               if (bus.eoi_id == ID_WIDTH'(i) && isr[i]) begin
                  eoi_hit = 1'b1;
                  eoi_k   = bus.eoi_id;
               end
            end
         end else if (isr_found) begin
            eoi_hit = 1'b1;
            eoi_k   = top_isr_id;
         end
      end
   end

   // Decode grant / EOI targets to one-hot vectors and validate set_priority_id.
   always_comb begin
      grant     = bus.ack && (state == StPending) && win_found;
      grant_vec = '0;
      eoi_clear = '0;
      set_ok    = 1'b0;
      for (int unsigned i = 0; i < CHANNELS; i++) begin
         grant_vec[i] = grant && (win_id == ID_WIDTH'(i));
         eoi_clear[i] = eoi_hit && (eoi_k == ID_WIDTH'(i));
         if (bus.set_priority_id == ID_WIDTH'(i)) set_ok = bus.set_priority;
      end
   end

   // All state: request/in-service registers, pointer, handshake FSM and its outputs.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state     <= StIdle;
         irr       <= '0;
         isr       <= '0;
         irq_prev  <= '0;
         pointer   <= '0;
         grant_id  <= '0;
         int_req   <= 1'b0;
         ack_pulse <= 1'b0;
      end else begin
         irq_prev <= bus.irq;
         // A fresh edge on a channel being granted stays pending (set wins).
         if (bus.level_triggered) irr <= bus.irq;
         else                     irr <= (irr & ~grant_vec) | (bus.irq & ~irq_prev);
         // A same-cycle ack on the EOI target re-sets the bit.
         isr <= (isr & ~eoi_clear) | grant_vec;
         if (set_ok)                          pointer <= next_id(bus.set_priority_id);
         else if (bus.auto_rotate && eoi_hit) pointer <= next_id(eoi_k);
         ack_pulse <= bus.ack;
         if (bus.ack) grant_id <= grant ? win_id : LastId;
         unique case (state)
            StIdle: begin
               if (win_found) begin
                  state   <= StPending;
                  int_req <= 1'b1;
               end
            end
            StPending: begin
               if (bus.ack || !win_found) begin
                  state   <= StIdle;
                  int_req <= 1'b0;
               end
            end
            default: begin
               state   <= StIdle;
               int_req <= 1'b0;
            end
         endcase
      end
   end

   assign bus.int_out                    = int_req;
   assign bus.ack_valid                  = ack_pulse;
   assign bus.ack_id                     = grant_id;
   assign bus.interrupt_request_register = irr;
   assign bus.in_service_register        = isr;
   assign bus.priority_pointer           = pointer;

endmodule
